// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions used by the instruction encoder and the control unit.
package mips_pkg;

  // Mnemonic codes accepted by the encoder; values 11-15 are illegal.
  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_NOR  = 4'd4,
    MN_SLT  = 4'd5,
    MN_LW   = 4'd6,
    MN_SW   = 4'd7,
    MN_BEQ  = 4'd8,
    MN_ADDI = 4'd9,
    MN_J    = 4'd10
  } mnem_t;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes.
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Encoder sequencing states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } enc_state_t;

  // R-type word: shamt is always zero for the supported operations.
  function automatic logic [31:0] pack_rtype(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type word: opcode, base/source register, target register, immediate.
  function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: mnemonic plus operand fields to a 32-bit MIPS word.
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  // Select the instruction format from the mnemonic; unknown codes give legal=0 and a zero word.
  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (mnem)
      MN_ADD:  word = pack_rtype(rs, rt, rd, FUNCT_ADD);
      MN_SUB:  word = pack_rtype(rs, rt, rd, FUNCT_SUB);
      MN_AND:  word = pack_rtype(rs, rt, rd, FUNCT_AND);
      MN_OR:   word = pack_rtype(rs, rt, rd, FUNCT_OR);
      MN_NOR:  word = pack_rtype(rs, rt, rd, FUNCT_NOR);
      MN_SLT:  word = pack_rtype(rs, rt, rd, FUNCT_SLT);
      MN_LW:   word = pack_itype(OP_LW, rs, rt, imm);
      MN_SW:   word = pack_itype(OP_SW, rs, rt, imm);
      MN_BEQ:  word = pack_itype(OP_BEQ, rs, rt, imm);
      MN_ADDI: word = pack_itype(OP_ADDI, rs, rt, imm);
      MN_J:    word = {OP_J, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests and writes them to consecutive instruction-memory words.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_mnem,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  rewind,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  enc_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic                    pend_q, pend_d;
  logic                    ready;
  logic                    pack_legal;
  logic [31:0]             pack_word;

  instr_pack u_pack (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .legal  (pack_legal),
    .word   (pack_word)
  );

  // count never exceeds 2**ADDR_WIDTH, so its top bit alone marks a full memory.
  assign full      = count_q[ADDR_WIDTH];
  assign in_ready  = ready;
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

  // Next-state logic: handshake, write hold-until-ack, and immediate or deferred rewind.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    pend_d  = pend_q;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = !full && !rewind;
        if (rewind) begin
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
        end else if (in_valid && ready) begin
          if (pack_legal) begin
            wdata_d = pack_word;
            state_d = ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (rewind) begin
          pend_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = ST_IDLE;
          if (pend_q || rewind) begin
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            pend_d  = 1'b0;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            count_d = count_q + (ADDR_WIDTH+1)'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any write in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder (default size plus a 4-word instance).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_ack = 1'b0;
  logic        drv_rewind = 1'b0;
  logic        sel_small = 1'b0;
  logic [3:0]  mnem = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] tgt = '0;

  logic        m_valid, m_ack, m_rewind, m_ready, m_we, m_full, m_err;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic [6:0]  m_count;
  logic        s_valid, s_ack, s_rewind, s_ready, s_we, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  logic        obs_ready, obs_we, obs_full, obs_err;
  logic [5:0]  obs_addr;
  logic [31:0] obs_wdata;
  logic [6:0]  obs_count;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int exp_addr = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  assign m_valid  = drv_valid & ~sel_small;
  assign m_ack    = drv_ack & ~sel_small;
  assign m_rewind = drv_rewind & ~sel_small;
  assign s_valid  = drv_valid & sel_small;
  assign s_ack    = drv_ack & sel_small;
  assign s_rewind = drv_rewind & sel_small;

  assign obs_ready = sel_small ? s_ready : m_ready;
  assign obs_we    = sel_small ? s_we : m_we;
  assign obs_full  = sel_small ? s_full : m_full;
  assign obs_err   = sel_small ? s_err : m_err;
  assign obs_addr  = sel_small ? {4'b0, s_addr} : m_addr;
  assign obs_wdata = sel_small ? s_wdata : m_wdata;
  assign obs_count = sel_small ? {4'b0, s_count} : m_count;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .in_ready(m_ready),
    .in_mnem(mnem), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(tgt),
    .rewind(m_rewind), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_ack(m_ack), .count(m_count), .full(m_full), .err(m_err)
  );

  instr_encoder #(.ADDR_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
    .in_mnem(mnem), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(tgt),
    .rewind(s_rewind), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_ack(s_ack), .count(s_count), .full(s_full), .err(s_err)
  );

  // Reference encoding built straight from the MIPS opcode/funct tables.
  function automatic logic [31:0] ref_word(input logic [3:0] m, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] c,
                                           input logic [15:0] i, input logic [25:0] t);
    case (m)
      4'd0:    return {6'h00, a, b, c, 5'd0, 6'h20};
      4'd1:    return {6'h00, a, b, c, 5'd0, 6'h22};
      4'd2:    return {6'h00, a, b, c, 5'd0, 6'h24};
      4'd3:    return {6'h00, a, b, c, 5'd0, 6'h25};
      4'd4:    return {6'h00, a, b, c, 5'd0, 6'h27};
      4'd5:    return {6'h00, a, b, c, 5'd0, 6'h2A};
      4'd6:    return {6'h23, a, b, i};
      4'd7:    return {6'h2B, a, b, i};
      4'd8:    return {6'h04, a, b, i};
      4'd9:    return {6'h08, a, b, i};
      4'd10:   return {6'h02, t};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one request, wait (bounded) for the handshake, queue the expected write.
  task automatic applyStimulus(input logic [3:0] m, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] c, input logic [15:0] i, input logic [25:0] t,
                               input logic [31:0] word, input bit legal);
    bit accepted;
    mnem = m; rs = a; rt = b; rd = c; imm = i; tgt = t;
    drv_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) begin
      #1;
      accepted = obs_ready;
      tick();
    end
    drv_valid = 1'b0;
    checkOutput("accept", 64'(accepted), 64'd1);
    if (legal) sb.push_back('{addr: 6'(exp_addr), word: word});
  endtask

  // Hold the write for delay cycles checking it is stable, then acknowledge it.
  task automatic ack_write(input int delay, input bit rewound);
    exp_t e;
    int cap;
    cap = sel_small ? 4 : 64;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k <= delay; k++) begin
      checkOutput("mem_we", 64'(obs_we), 64'd1);
      checkOutput("mem_addr", 64'(obs_addr), 64'(e.addr));
      checkOutput("mem_wdata", 64'(obs_wdata), 64'(e.word));
      checkOutput("ready_busy", 64'(obs_ready), 64'd0);
      if (k == delay) drv_ack = 1'b1;
      tick();
    end
    drv_ack = 1'b0;
    if (rewound) begin
      exp_addr = 0;
      exp_count = 0;
    end else begin
      exp_addr++;
      exp_count++;
    end
    #1;
    checkOutput("mem_we_done", 64'(obs_we), 64'd0);
    checkOutput("count", 64'(obs_count), 64'(exp_count));
    checkOutput("ready_after", 64'(obs_ready), 64'(exp_count != cap));
  endtask

  task automatic do_rewind();
    drv_rewind = 1'b1;
    #1;
    checkOutput("ready_rewind", 64'(obs_ready), 64'd0);
    tick();
    drv_rewind = 1'b0;
    exp_addr = 0;
    exp_count = 0;
    #1;
    checkOutput("rw_count", 64'(obs_count), 64'd0);
    checkOutput("rw_full", 64'(obs_full), 64'd0);
    checkOutput("rw_err", 64'(obs_err), 64'd0);
    checkOutput("rw_addr", 64'(obs_addr), 64'd0);
    checkOutput("rw_ready", 64'(obs_ready), 64'd1);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_we", 64'(obs_we), 64'd0);
    checkOutput("rst_addr", 64'(obs_addr), 64'd0);
    checkOutput("rst_wdata", 64'(obs_wdata), 64'd0);
    checkOutput("rst_count", 64'(obs_count), 64'd0);
    checkOutput("rst_full", 64'(obs_full), 64'd0);
    checkOutput("rst_err", 64'(obs_err), 64'd0);
    checkOutput("rst_ready", 64'(obs_ready), 64'd1);
  endtask

  // Directed sequence covering the main function and its boundary cases.
  initial begin
    $display("[TB] start");
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_reset_values();

    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1'b1);
    ack_write(0, 1'b0);
    do_rewind();

    applyStimulus(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h8FA80004, 1'b1);
    ack_write(0, 1'b0);
    applyStimulus(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, 1'b1);
    ack_write(0, 1'b0);
    applyStimulus(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h08000010, 1'b1);
    ack_write(0, 1'b0);

    applyStimulus(4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0,
                  ref_word(4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0), 1'b1);
    mnem = 4'd1; rs = 5'd4; rt = 5'd5; rd = 5'd6;
    drv_valid = 1'b1;
    ack_write(3, 1'b0);
    applyStimulus(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0,
                  ref_word(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0), 1'b1);
    ack_write(1, 1'b0);

    applyStimulus(4'd13, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h0, 1'b0);
    #1;
    checkOutput("illegal_err", 64'(obs_err), 64'd1);
    checkOutput("illegal_we", 64'(obs_we), 64'd0);
    checkOutput("illegal_count", 64'(obs_count), 64'(exp_count));

    applyStimulus(4'd5, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0,
                  ref_word(4'd5, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0), 1'b1);
    drv_rewind = 1'b1;
    #1;
    checkOutput("rw_write_ready", 64'(obs_ready), 64'd0);
    tick();
    drv_rewind = 1'b0;
    ack_write(1, 1'b1);
    checkOutput("rw_write_err", 64'(obs_err), 64'd0);
    checkOutput("rw_write_addr", 64'(obs_addr), 64'd0);

    applyStimulus(4'd9, 5'd3, 5'd4, 5'd0, 16'h8001, 26'h0,
                  ref_word(4'd9, 5'd3, 5'd4, 5'd0, 16'h8001, 26'h0), 1'b1);
    ack_write(0, 1'b0);
    applyStimulus(4'd7, 5'd31, 5'd17, 5'd0, 16'h1234, 26'h0,
                  ref_word(4'd7, 5'd31, 5'd17, 5'd0, 16'h1234, 26'h0), 1'b1);
    ack_write(2, 1'b0);

    drv_ack = 1'b1;
    tick();
    drv_ack = 1'b0;
    #1;
    checkOutput("stray_ack_count", 64'(obs_count), 64'(exp_count));
    checkOutput("stray_ack_we", 64'(obs_we), 64'd0);

    applyStimulus(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0,
                  ref_word(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0), 1'b1);
    checkOutput("pre_rst_we", 64'(obs_we), 64'd1);
    rst_n = 1'b0;
    tick();
    check_reset_values();
    rst_n = 1'b1;
    sb.delete();
    exp_addr = 0;
    exp_count = 0;
    tick();
    check_reset_values();

    sel_small = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(4'(n), 5'(n + 1), 5'(n + 2), 5'(n + 3), 16'h0, 26'h0,
                    ref_word(4'(n), 5'(n + 1), 5'(n + 2), 5'(n + 3), 16'h0, 26'h0), 1'b1);
      ack_write(0, 1'b0);
    end
    checkOutput("small_full", 64'(obs_full), 64'd1);
    drv_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      checkOutput("full_ready", 64'(obs_ready), 64'd0);
      tick();
      checkOutput("full_we", 64'(obs_we), 64'd0);
    end
    drv_valid = 1'b0;
    do_rewind();
    applyStimulus(4'd9, 5'd2, 5'd2, 5'd0, 16'h0042, 26'h0,
                  ref_word(4'd9, 5'd2, 5'd2, 5'd0, 16'h0042, 26'h0), 1'b1);
    ack_write(0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
